// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register: captures the decode control/data bundle,
// supports bubble insertion (flush) and hold (stall), and counts inserted bubbles.
module id_ex_reg #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_e,
  input  logic             stall_e,
  input  logic             reg_write_d,
  input  logic             mem_write_d,
  input  logic             jump_d,
  input  logic             branch_d,
  input  logic             alusrc_d,
  input  logic             pc_src2_d,
  input  logic             lui_signal_d,
  input  logic [1:0]       result_src_d,
  input  logic [2:0]       alucontrol_d,
  input  logic [XLEN-1:0]  rd1_d,
  input  logic [XLEN-1:0]  rd2_d,
  input  logic [XLEN-1:0]  imm_ext_d,
  input  logic [XLEN-1:0]  pc_d,
  input  logic [XLEN-1:0]  pc_plus4_d,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rd_d,
  output logic             reg_write_e,
  output logic             mem_write_e,
  output logic             jump_e,
  output logic             branch_e,
  output logic             alusrc_e,
  output logic             pc_src2_e,
  output logic             lui_signal_e,
  output logic [1:0]       result_src_e,
  output logic [2:0]       alucontrol_e,
  output logic [XLEN-1:0]  rd1_e,
  output logic [XLEN-1:0]  rd2_e,
  output logic [XLEN-1:0]  imm_ext_e,
  output logic [XLEN-1:0]  pc_e,
  output logic [XLEN-1:0]  pc_plus4_e,
  output logic [4:0]       rs1_e,
  output logic [4:0]       rs2_e,
  output logic [4:0]       rd_e,
  output logic             valid_e,
  output logic [CNT_W-1:0] bubble_cnt
);

  always_ff @(posedge clk) begin
    if (rst || flush_e) begin
      // A bubble zeroes data/index fields too, so rd_e=x0 never matches forwarding.
      reg_write_e  <= 1'b0;
      mem_write_e  <= 1'b0;
      jump_e       <= 1'b0;
      branch_e     <= 1'b0;
      alusrc_e     <= 1'b0;
      pc_src2_e    <= 1'b0;
      lui_signal_e <= 1'b0;
      result_src_e <= '0;
      alucontrol_e <= '0;
      rd1_e        <= '0;
      rd2_e        <= '0;
      imm_ext_e    <= '0;
      pc_e         <= '0;
      pc_plus4_e   <= '0;
      rs1_e        <= '0;
      rs2_e        <= '0;
      rd_e         <= '0;
      valid_e      <= 1'b0;
    end else if (!stall_e) begin
      reg_write_e  <= reg_write_d;
      mem_write_e  <= mem_write_d;
      jump_e       <= jump_d;
      branch_e     <= branch_d;
      alusrc_e     <= alusrc_d;
      pc_src2_e    <= pc_src2_d;
      lui_signal_e <= lui_signal_d;
      result_src_e <= result_src_d;
      alucontrol_e <= alucontrol_d;
      rd1_e        <= rd1_d;
      rd2_e        <= rd2_d;
      imm_ext_e    <= imm_ext_d;
      pc_e         <= pc_d;
      pc_plus4_e   <= pc_plus4_d;
      rs1_e        <= rs1_d;
      rs2_e        <= rs2_d;
      rd_e         <= rd_d;
      valid_e      <= 1'b1;
    end
  end

  // Saturating bubble counter; stall edges do not count.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (flush_e && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: directed hazard scenarios plus random traffic
// checked against a bundle-level reference model.
module tb_id_ex_reg;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alusrc;
    logic        pc_src2;
    logic        lui;
    logic [1:0]  result_src;
    logic [2:0]  alucontrol;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } bundle_t;

  typedef struct packed {
    bundle_t    b;
    logic       v;
    logic [3:0] c;
  } exp_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    flush_e = 1'b0;
  logic    stall_e = 1'b0;
  bundle_t d_in = '0;
  bundle_t act;
  logic    valid_e;
  logic [3:0] bubble_cnt;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  bundle_t m_b = '0;
  logic    m_v = 1'b0;
  int      m_c = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.XLEN(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush_e(flush_e), .stall_e(stall_e),
    .reg_write_d(d_in.reg_write), .mem_write_d(d_in.mem_write), .jump_d(d_in.jump),
    .branch_d(d_in.branch), .alusrc_d(d_in.alusrc), .pc_src2_d(d_in.pc_src2),
    .lui_signal_d(d_in.lui), .result_src_d(d_in.result_src), .alucontrol_d(d_in.alucontrol),
    .rd1_d(d_in.rd1), .rd2_d(d_in.rd2), .imm_ext_d(d_in.imm), .pc_d(d_in.pc),
    .pc_plus4_d(d_in.pc4), .rs1_d(d_in.rs1), .rs2_d(d_in.rs2), .rd_d(d_in.rd),
    .reg_write_e(act.reg_write), .mem_write_e(act.mem_write), .jump_e(act.jump),
    .branch_e(act.branch), .alusrc_e(act.alusrc), .pc_src2_e(act.pc_src2),
    .lui_signal_e(act.lui), .result_src_e(act.result_src), .alucontrol_e(act.alucontrol),
    .rd1_e(act.rd1), .rd2_e(act.rd2), .imm_ext_e(act.imm), .pc_e(act.pc),
    .pc_plus4_e(act.pc4), .rs1_e(act.rs1), .rs2_e(act.rs2), .rd_e(act.rd),
    .valid_e(valid_e), .bubble_cnt(bubble_cnt)
  );

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.reg_write  = 1'($urandom);
    b.mem_write  = 1'($urandom);
    b.jump       = 1'($urandom);
    b.branch     = 1'($urandom);
    b.alusrc     = 1'($urandom);
    b.pc_src2    = 1'($urandom);
    b.lui        = 1'($urandom);
    b.result_src = 2'($urandom);
    b.alucontrol = 3'($urandom);
    b.rd1        = $urandom;
    b.rd2        = $urandom;
    b.imm        = $urandom;
    b.pc         = $urandom & 32'hFFFF_FFFC;
    b.pc4        = b.pc + 32'd4;
    b.rs1        = 5'($urandom);
    b.rs2        = 5'($urandom);
    b.rd         = 5'($urandom);
    return b;
  endfunction

  // Drive one edge's inputs and record what the execute stage should hold after it.
  task automatic step(input bundle_t d, input logic r, input logic fl, input logic st);
    exp_t e;
    @(negedge clk);
    d_in = d; rst = r; flush_e = fl; stall_e = st;
    if (r) begin
      m_b = '0; m_v = 1'b0; m_c = 0;
    end else if (fl) begin
      m_b = '0; m_v = 1'b0;
      m_c = (m_c >= 15) ? 15 : m_c + 1;
    end else if (!st) begin
      m_b = d; m_v = 1'b1;
    end
    e.b = m_b; e.v = m_v; e.c = 4'(m_c);
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        n_checks++;
        if (act !== e.b) begin
          n_fail++;
          $display("FAIL bundle t=%0t actual=%h required=%h", $time, act, e.b);
        end
        n_checks++;
        if (valid_e !== e.v) begin
          n_fail++;
          $display("FAIL valid_e t=%0t actual=%b required=%b", $time, valid_e, e.v);
        end
        n_checks++;
        if (bubble_cnt !== e.c) begin
          n_fail++;
          $display("FAIL bubble_cnt t=%0t actual=%0d required=%0d", $time, bubble_cnt, e.c);
        end
      end
    end
  end

  initial begin : stim
    bundle_t b, sw;
    logic r, fl, st;
    // Reset with all inputs high.
    step('1, 1'b1, 1'b1, 1'b1);
    // lw pass-through.
    b = '0; b.reg_write = 1'b1; b.result_src = 2'b01; b.alusrc = 1'b1;
    b.rd = 5'd5; b.imm = 32'h10; b.pc = 32'h40; b.pc4 = 32'h44; b.rs1 = 5'd2;
    step(b, 1'b0, 1'b0, 1'b0);
    // jal then 3 stalls while sw is presented, then release.
    b = '0; b.jump = 1'b1; b.result_src = 2'b10; b.rd = 5'd1; b.pc = 32'h80; b.pc4 = 32'h84;
    step(b, 1'b0, 1'b0, 1'b0);
    sw = '0; sw.mem_write = 1'b1; sw.alusrc = 1'b1; sw.rs1 = 5'd3; sw.rs2 = 5'd4;
    sw.imm = 32'h8; sw.rd2 = 32'hDEAD_BEEF; sw.pc = 32'h84; sw.pc4 = 32'h88;
    for (int i = 0; i < 3; i++) step(sw, 1'b0, 1'b0, 1'b1);
    step(sw, 1'b0, 1'b0, 1'b0);
    // R-type add, then flush and stall together.
    b = '0; b.reg_write = 1'b1; b.rd = 5'd7; b.rs1 = 5'd1; b.rs2 = 5'd2; b.rd1 = 32'd9;
    step(b, 1'b0, 1'b0, 1'b0);
    step(rand_bundle(), 1'b0, 1'b1, 1'b1);
    // Reserved ALU code passes through unchanged.
    b = rand_bundle(); b.alucontrol = 3'b111;
    step(b, 1'b0, 1'b0, 1'b0);
    b.alucontrol = 3'b100;
    step(b, 1'b0, 1'b0, 1'b0);
    // Saturation: reset, then 20 consecutive flushes.
    step(rand_bundle(), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(rand_bundle(), 1'b0, 1'b1, 1'b0);
    // Reset mid-stream while stalled with valid content.
    step(rand_bundle(), 1'b0, 1'b0, 1'b0);
    step(rand_bundle(), 1'b0, 1'b0, 1'b1);
    step(rand_bundle(), 1'b1, 1'b0, 1'b1);
    step(rand_bundle(), 1'b0, 1'b0, 1'b0);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(99) < 3);
      fl = ($urandom_range(99) < 15);
      st = ($urandom_range(99) < 25);
      step(rand_bundle(), r, fl, st);
    end
    @(posedge clk);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
